// File: rtl/pid_term_sequencer_pkg.sv
// Shared constants and types for the I-PD term sequencer and its fixed-point helpers.
package pid_term_sequencer_pkg;

    localparam int N    = 23;
    localparam int FRAC = 10;

    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_MUL_D = 3'd4,
        ST_SUM   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/pid_term_sequencer_if.sv
// Bundle between the ADC/gain source (master) and the term sequencer (slave).
interface pid_term_sequencer_if;
    import pid_term_sequencer_pkg::*;

    logic                sample_valid;
    logic signed [N-1:0] y;
    logic signed [N-1:0] ref_val;
    logic signed [N-1:0] kp;
    logic signed [N-1:0] ki;
    logic signed [N-1:0] kd;
    logic                int_clr;
    logic signed [N-1:0] ik;
    logic signed [N-1:0] pk;
    logic signed [N-1:0] dk;
    logic                sum_en;
    logic                done;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_valid, y, ref_val, kp, ki, kd, int_clr,
        input  ik, pk, dk, sum_en, done, busy, overrun
    );

    modport slave (
        input  sample_valid, y, ref_val, kp, ki, kd, int_clr,
        output ik, pk, dk, sum_en, done, busy, overrun
    );

endinterface

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift by FRAC,
// then saturation back to W bits.
module fx_mul_sat #(
    parameter int W    = 23,
    parameter int FRAC = 10
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o
);

    localparam int PW = 2 * W;

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shift_s;

    // Product, rescale, and clamp when the upper bits are not pure sign extension
    always_comb begin
        prod_s  = PW'(a_i) * PW'(b_i);
        shift_s = prod_s >>> FRAC;
        if (shift_s[PW-1:W-1] == {(W+1){shift_s[PW-1]}}) begin
            p_o = shift_s[W-1:0];
        end else if (shift_s[PW-1]) begin
            p_o = {1'b1, {(W-1){1'b0}}};
        end else begin
            p_o = {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pid_term_sequencer.sv
// One I-PD update per sample strobe: P, I and D terms share one multiplier,
// then the summer is enabled for a single cycle.
module pid_term_sequencer
    import pid_term_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pid_term_sequencer_if.slave  seq_if
);

    function automatic logic signed [N-1:0] sat_n1(input logic signed [N:0] v);
        if (v[N] != v[N-1]) begin
            return v[N] ? SAT_MIN : SAT_MAX;
        end else begin
            return v[N-1:0];
        end
    endfunction

    state_e state_q, state_d;

    logic signed [N-1:0] y_q, ref_q, kp_q, ki_q, kd_q;
    logic signed [N-1:0] e_q, dy_q, y_prev_q;
    logic signed [N-1:0] ik_q, pk_q, dk_q;
    logic                primed_q, sum_en_q, done_q, busy_q, overrun_q;
    logic signed [N-1:0] mul_a_s, mul_b_s, mul_p_s;

    // Next-state sequencing: every non-idle state is a single cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = seq_if.sample_valid ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = ST_MUL_P;
            ST_MUL_P: state_d = ST_MUL_I;
            ST_MUL_I: state_d = ST_MUL_D;
            ST_MUL_D: state_d = ST_SUM;
            ST_SUM:   state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Multiplier operand select decoded from the current state
    always_comb begin
        mul_a_s = {N{1'b0}};
        mul_b_s = {N{1'b0}};
        case (state_q)
            ST_MUL_P: begin mul_a_s = kp_q; mul_b_s = y_q;  end
            ST_MUL_I: begin mul_a_s = ki_q; mul_b_s = e_q;  end
            ST_MUL_D: begin mul_a_s = kd_q; mul_b_s = dy_q; end
            default:  begin mul_a_s = {N{1'b0}}; mul_b_s = {N{1'b0}}; end
        endcase
    end

    fx_mul_sat #(.W(N), .FRAC(FRAC)) u_mul (
        .a_i (mul_a_s),
        .b_i (mul_b_s),
        .p_o (mul_p_s)
    );

    // State, operand latches, terms and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            y_q       <= {N{1'b0}};
            ref_q     <= {N{1'b0}};
            kp_q      <= {N{1'b0}};
            ki_q      <= {N{1'b0}};
            kd_q      <= {N{1'b0}};
            e_q       <= {N{1'b0}};
            dy_q      <= {N{1'b0}};
            y_prev_q  <= {N{1'b0}};
            ik_q      <= {N{1'b0}};
            pk_q      <= {N{1'b0}};
            dk_q      <= {N{1'b0}};
            primed_q  <= 1'b0;
            sum_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_en_q <= (state_d == ST_SUM);
            done_q   <= (state_d == ST_DONE);
            busy_q   <= (state_d != ST_IDLE);
            if (seq_if.sample_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (seq_if.sample_valid) begin
                        y_q   <= seq_if.y;
                        ref_q <= seq_if.ref_val;
                        kp_q  <= seq_if.kp;
                        ki_q  <= seq_if.ki;
                        kd_q  <= seq_if.kd;
                    end else if (seq_if.int_clr) begin
                        ik_q <= {N{1'b0}};
                    end
                end
                ST_LOAD: begin
                    e_q  <= sat_n1({ref_q[N-1], ref_q} - {y_q[N-1], y_q});
                    dy_q <= primed_q ? sat_n1({y_q[N-1], y_q} - {y_prev_q[N-1], y_prev_q})
                                     : {N{1'b0}};
                end
                ST_MUL_P: pk_q <= mul_p_s;
                ST_MUL_I: ik_q <= sat_n1({ik_q[N-1], ik_q} + {mul_p_s[N-1], mul_p_s});
                ST_MUL_D: begin
                    dk_q     <= mul_p_s;
                    y_prev_q <= y_q;
                    primed_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign seq_if.ik      = ik_q;
    assign seq_if.pk      = pk_q;
    assign seq_if.dk      = dk_q;
    assign seq_if.sum_en  = sum_en_q;
    assign seq_if.done    = done_q;
    assign seq_if.busy    = busy_q;
    assign seq_if.overrun = overrun_q;

endmodule

// File: tb/tb_pid_term_sequencer.sv
// Self-checking bench for pid_term_sequencer against an arithmetic reference model.
module tb_pid_term_sequencer;

    localparam longint SMAX = 64'sd4194303;
    localparam longint SMIN = -64'sd4194304;
    localparam logic [8:1] BUSY_EXP = 8'b0011_1111;
    localparam logic [8:1] SUM_EXP  = 8'b0001_0000;
    localparam logic [8:1] DONE_EXP = 8'b0010_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pid_term_sequencer_if bus();
    pid_term_sequencer dut (.clk(clk), .reset(reset), .seq_if(bus));

    int n_cmp = 0;
    int n_bad = 0;

    longint m_ik, m_pk, m_dk, m_yprev;
    bit     m_primed;
    logic [8:1] busy_t, sum_t, done_t;

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Floor division by 1024, then clamp
    function automatic longint fmul(input longint a, input longint b);
        longint p, q;
        p = a * b;
        q = p / 1024;
        if (p < 0 && (p % 1024) != 0) q = q - 1;
        return sat(q);
    endfunction

    function automatic void model_reset();
        m_ik = 0; m_pk = 0; m_dk = 0; m_yprev = 0; m_primed = 1'b0;
    endfunction

    function automatic void model_update(input longint y, input longint r, input longint kp,
                                         input longint ki, input longint kd);
        longint e, dy;
        e  = sat(r - y);
        dy = m_primed ? sat(y - m_yprev) : 0;
        m_pk = fmul(kp, y);
        m_ik = sat(m_ik + fmul(ki, e));
        m_dk = fmul(kd, dy);
        m_yprev = y;
        m_primed = 1'b1;
    endfunction

    function automatic longint rnd(input bit full);
        logic signed [22:0] t;
        t = 23'($urandom);
        if (full) return longint'(t);
        return longint'($urandom_range(0, 8191)) - 64'sd4096;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        bus.sample_valid = 1'b0; bus.int_clr = 1'b0;
        bus.y = '0; bus.ref_val = '0; bus.kp = '0; bus.ki = '0; bus.kd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Strobe one sample, scramble inputs afterwards, record flags over cycles 1..8
    task automatic do_update(input longint y, input longint r, input longint kp,
                             input longint ki, input longint kd, input bit clr);
        bus.y = 23'(y); bus.ref_val = 23'(r);
        bus.kp = 23'(kp); bus.ki = 23'(ki); bus.kd = 23'(kd);
        bus.int_clr = clr;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0; bus.int_clr = 1'b0;
        bus.y = 23'($urandom); bus.ref_val = 23'($urandom);
        bus.kp = 23'($urandom); bus.ki = 23'($urandom); bus.kd = 23'($urandom);
        model_update(y, r, kp, ki, kd);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            busy_t[c] = bus.busy; sum_t[c] = bus.sum_en; done_t[c] = bus.done;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if ({bus.ik, bus.pk, bus.dk} !== 69'd0) begin n_bad++;
            $display("FAIL reset_terms: got ik=%0d pk=%0d dk=%0d expected 0", bus.ik, bus.pk, bus.dk); end
        n_cmp++; if ({bus.sum_en, bus.done, bus.busy, bus.overrun} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.sum_en, bus.done, bus.busy, bus.overrun}); end
    endtask

    task automatic test_single();
        apply_reset();
        do_update(1536, 1536, 2048, 0, 0, 1'b0);
        n_cmp++; if (bus.pk !== 23'sd3072) begin n_bad++;
            $display("FAIL single_pk: got %0d expected 3072", bus.pk); end
        n_cmp++; if (bus.ik !== 23'sd0 || bus.dk !== 23'sd0) begin n_bad++;
            $display("FAIL single_ik_dk: got ik=%0d dk=%0d expected 0 0", bus.ik, bus.dk); end
        n_cmp++; if (busy_t !== BUSY_EXP) begin n_bad++;
            $display("FAIL single_busy: got %b expected %b", busy_t, BUSY_EXP); end
        n_cmp++; if (sum_t !== SUM_EXP) begin n_bad++;
            $display("FAIL single_sum_en: got %b expected %b", sum_t, SUM_EXP); end
        n_cmp++; if (done_t !== DONE_EXP) begin n_bad++;
            $display("FAIL single_done: got %b expected %b", done_t, DONE_EXP); end
    endtask

    task automatic test_integrator();
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            do_update(1024, 2048, 0, 512, 0, 1'b0);
            n_cmp++; if (bus.ik !== 23'(512 * k) || bus.ik !== 23'(m_ik)) begin n_bad++;
                $display("FAIL integ_ik%0d: got %0d expected %0d", k, bus.ik, 512 * k); end
            repeat (2) @(negedge clk);
        end
        bus.int_clr = 1'b1;
        @(posedge clk);
        #1 bus.int_clr = 1'b0;
        m_ik = 0;
        @(negedge clk);
        n_cmp++; if (bus.ik !== 23'sd0) begin n_bad++;
            $display("FAIL integ_clear: got %0d expected 0", bus.ik); end
        do_update(1024, 2048, 0, 512, 0, 1'b1);
        n_cmp++; if (bus.ik !== 23'sd512 || bus.ik !== 23'(m_ik)) begin n_bad++;
            $display("FAIL integ_strobe_wins: got %0d expected 512", bus.ik); end
    endtask

    task automatic test_derivative();
        longint ys[3] = '{1024, 1536, 512};
        longint dks[3] = '{0, 512, -1024};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_update(ys[k], 0, 0, 0, 1024, 1'b0);
            n_cmp++; if (bus.dk !== 23'(dks[k]) || bus.dk !== 23'(m_dk)) begin n_bad++;
                $display("FAIL deriv_dk%0d: got %0d expected %0d", k, bus.dk, dks[k]); end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            do_update(SMIN, SMAX, 0, SMAX, 0, 1'b0);
            n_cmp++; if (bus.ik !== 23'(SMAX) || bus.ik !== 23'(m_ik)) begin n_bad++;
                $display("FAIL sat_ik%0d: got %0d expected %0d", k, bus.ik, SMAX); end
        end
    endtask

    task automatic test_overrun();
        int n_sum, n_done;
        apply_reset();
        bus.y = 23'sd1024; bus.ref_val = 23'sd2048; bus.kp = 23'sd1024;
        bus.ki = 23'sd512; bus.kd = 23'sd0;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1 bus.sample_valid = 1'b0;
        model_update(1024, 2048, 1024, 512, 0);
        repeat (3) @(negedge clk);
        bus.y = 23'sd3000; bus.kp = 23'sd4000; bus.ki = 23'sd4000;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1 bus.sample_valid = 1'b0;
        n_sum = 0; n_done = 0;
        for (int c = 4; c <= 9; c++) begin
            @(negedge clk);
            n_sum += int'(bus.sum_en); n_done += int'(bus.done);
        end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++;
            $display("FAIL ovr_flag: got %b expected 1", bus.overrun); end
        n_cmp++; if (bus.pk !== 23'(m_pk) || bus.ik !== 23'(m_ik)) begin n_bad++;
            $display("FAIL ovr_inflight: got pk=%0d ik=%0d expected %0d %0d", bus.pk, bus.ik, m_pk, m_ik); end
        n_cmp++; if (n_sum != 1 || n_done != 1) begin n_bad++;
            $display("FAIL ovr_pulses: got sum=%0d done=%0d expected 1 1", n_sum, n_done); end
        do_update(512, 1024, 2048, 1024, 0, 1'b0);
        n_cmp++; if (bus.pk !== 23'(m_pk) || bus.ik !== 23'(m_ik) || sum_t !== SUM_EXP) begin n_bad++;
            $display("FAIL ovr_next: got pk=%0d ik=%0d sum=%b expected %0d %0d %b",
                     bus.pk, bus.ik, sum_t, m_pk, m_ik, SUM_EXP); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++;
            $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        do_update(700, 100, 1024, 1024, 1024, 1'b0);
        bus.y = 23'sd900; bus.ref_val = 23'sd50; bus.kp = 23'sd1024;
        bus.ki = 23'sd1024; bus.kd = 23'sd1024;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1 bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({bus.ik, bus.pk, bus.dk} !== 69'd0) begin n_bad++;
            $display("FAIL rstmid_terms: got ik=%0d pk=%0d dk=%0d expected 0", bus.ik, bus.pk, bus.dk); end
        n_cmp++; if ({bus.sum_en, bus.done, bus.busy, bus.overrun} !== 4'b0000) begin n_bad++;
            $display("FAIL rstmid_flags: got %b expected 0000", {bus.sum_en, bus.done, bus.busy, bus.overrun}); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        do_update(2000, 100, 512, 256, 1024, 1'b0);
        n_cmp++; if (bus.dk !== 23'sd0 || bus.pk !== 23'(m_pk) || bus.ik !== 23'(m_ik)) begin n_bad++;
            $display("FAIL rstmid_first: got dk=%0d pk=%0d ik=%0d expected 0 %0d %0d",
                     bus.dk, bus.pk, bus.ik, m_pk, m_ik); end
    endtask

    task automatic test_random();
        longint y, r, kp, ki, kd;
        bit full;
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            full = ($urandom_range(0, 3) == 0);
            y = rnd(full); r = rnd(full); kp = rnd(full); ki = rnd(full); kd = rnd(full);
            if ($urandom_range(0, 4) == 0) begin
                bus.int_clr = 1'b1;
                @(posedge clk);
                #1 bus.int_clr = 1'b0;
                m_ik = 0;
                @(negedge clk);
            end
            do_update(y, r, kp, ki, kd, 1'b0);
            n_cmp++; if (bus.ik !== 23'(m_ik) || bus.pk !== 23'(m_pk) || bus.dk !== 23'(m_dk)) begin n_bad++;
                $display("FAIL rand%0d: got ik=%0d pk=%0d dk=%0d expected %0d %0d %0d",
                         k, bus.ik, bus.pk, bus.dk, m_ik, m_pk, m_dk); end
            n_cmp++; if (sum_t !== SUM_EXP || done_t !== DONE_EXP) begin n_bad++;
                $display("FAIL rand%0d_pulses: got sum=%b done=%b expected %b %b",
                         k, sum_t, done_t, SUM_EXP, DONE_EXP); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single();
        test_integrator();
        test_derivative();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
